// File: rtl/vx_cluster_gbar_ctrl.sv
// Cluster-level global barrier controller.
// Tracks per-slot core arrival masks and emits a one-cycle release pulse once
// the expected number of cores has arrived at a slot. Never backpressures.
// Optional: define GBAR_CTRL_PERF_EN to add release / wait-cycle counters.
module vx_cluster_gbar_ctrl #(
  parameter int    NUM_BARRIERS = 4,
  parameter int    NUM_CORES    = 4,
  parameter string INSTANCE_ID  = "",
  localparam int   ID_W   = (NUM_BARRIERS > 1) ? $clog2(NUM_BARRIERS) : 1,
  localparam int   CORE_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  input  logic [ID_W-1:0]   req_id,
  input  logic [CORE_W-1:0] req_size_m1,
  input  logic [CORE_W-1:0] req_core_id,
  output logic              req_ready,
  output logic              rsp_valid,
  output logic [ID_W-1:0]   rsp_id,
  output logic              err_dup,
  output logic              err_size,
  output logic              busy
`ifdef GBAR_CTRL_PERF_EN
  , output logic [31:0]     perf_releases
  , output logic [43:0]     perf_wait_cycles
`endif
);

  logic [NUM_BARRIERS-1:0][NUM_CORES-1:0] mask_q, mask_d;
  logic [NUM_BARRIERS-1:0][CORE_W-1:0]    size_q, size_d;
  logic [NUM_BARRIERS-1:0]                active_q, active_d;
  logic                                   rsp_valid_q, rsp_valid_d;
  logic [ID_W-1:0]                        rsp_id_q, rsp_id_d;
  logic                                   err_dup_q, err_dup_d;
  logic                                   err_size_q, err_size_d;

  // Number of set bits in one arrival mask; wide enough to hold NUM_CORES.
  function automatic logic [CORE_W:0] popcnt(input logic [NUM_CORES-1:0] v);
    logic [CORE_W:0] c;
    c = '0;
    for (int i = 0; i < NUM_CORES; i++) c = c + (CORE_W+1)'(v[i]);
    return c;
  endfunction

  logic                  accept;
  logic [NUM_CORES-1:0]  cur_mask, new_mask, onehot;
  logic [CORE_W-1:0]     eff_size_m1;
  logic [CORE_W:0]       cnt, target;

  assign req_ready = 1'b1;
  assign accept    = req_valid & req_ready & (int'(req_id) < NUM_BARRIERS);

  // Arrival bookkeeping, completion detection and sticky error capture.
  always_comb begin
    mask_d      = mask_q;
    size_d      = size_q;
    active_d    = active_q;
    rsp_valid_d = 1'b0;
    rsp_id_d    = rsp_id_q;
    err_dup_d   = err_dup_q;
    err_size_d  = err_size_q;
    cur_mask    = '0;
    onehot      = '0;
    new_mask    = '0;
    eff_size_m1 = req_size_m1;
    cnt         = '0;
    target      = '0;
    if (accept) begin
      cur_mask    = mask_q[req_id];
      onehot      = NUM_CORES'(1) << req_core_id;
      new_mask    = cur_mask | onehot;
      cnt         = popcnt(new_mask);
      // A live slot keeps the size it was opened with, even if a later
      // arrival disagrees.
      eff_size_m1 = active_q[req_id] ? size_q[req_id] : req_size_m1;
      target      = {1'b0, eff_size_m1} + {{CORE_W{1'b0}}, 1'b1};
      if (active_q[req_id] && (req_size_m1 != size_q[req_id])) err_size_d = 1'b1;
      if ((cur_mask & onehot) != '0) err_dup_d = 1'b1;
      if (cnt == target) begin
        mask_d[req_id]   = '0;
        active_d[req_id] = 1'b0;
        rsp_valid_d      = 1'b1;
        rsp_id_d         = req_id;
      end else begin
        mask_d[req_id]   = new_mask;
        active_d[req_id] = 1'b1;
        if (!active_q[req_id]) size_d[req_id] = req_size_m1;
      end
    end
  end

  // State registers with synchronous reset; pending arrivals are dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      mask_q      <= '0;
      size_q      <= '0;
      active_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      err_dup_q   <= 1'b0;
      err_size_q  <= 1'b0;
    end else begin
      mask_q      <= mask_d;
      size_q      <= size_d;
      active_q    <= active_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      err_dup_q   <= err_dup_d;
      err_size_q  <= err_size_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign err_dup   = err_dup_q;
  assign err_size  = err_size_q;
  assign busy      = |mask_q;

`ifdef GBAR_CTRL_PERF_EN
  logic [31:0] perf_releases_q, perf_releases_d;
  logic [43:0] perf_wait_q, perf_wait_d;
  logic [43:0] waiting;

  // Count release pulses and accumulate core-cycles spent waiting.
  always_comb begin
    waiting = '0;
    for (int b = 0; b < NUM_BARRIERS; b++) waiting = waiting + 44'(popcnt(mask_q[b]));
    perf_releases_d = perf_releases_q + {31'd0, rsp_valid_q};
    perf_wait_d     = perf_wait_q + waiting;
  end

  // Perf counter registers; wrap naturally on overflow.
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_releases_q <= '0;
      perf_wait_q     <= '0;
    end else begin
      perf_releases_q <= perf_releases_d;
      perf_wait_q     <= perf_wait_d;
    end
  end

  assign perf_releases    = perf_releases_q;
  assign perf_wait_cycles = perf_wait_q;
`endif

endmodule

// File: tb/tb_vx_cluster_gbar_ctrl.sv
// Scoreboard bench for vx_cluster_gbar_ctrl: expected releases are queued when
// arrivals are driven and matched against rsp pulses (id and cycle).
module tb_vx_cluster_gbar_ctrl;
  localparam int NB = 4, NC = 4, IW = 2, CW = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          req_valid;
  logic [IW-1:0] req_id;
  logic [CW-1:0] req_size_m1, req_core_id;
  logic          req_ready, rsp_valid, err_dup, err_size, busy;
  logic [IW-1:0] rsp_id;
`ifdef GBAR_CTRL_PERF_EN
  logic [31:0]   perf_releases;
  logic [43:0]   perf_wait_cycles;
`endif

  vx_cluster_gbar_ctrl #(.NUM_BARRIERS(NB), .NUM_CORES(NC), .INSTANCE_ID("tb")) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_id(req_id),
    .req_size_m1(req_size_m1), .req_core_id(req_core_id), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .err_dup(err_dup), .err_size(err_size),
    .busy(busy)
`ifdef GBAR_CTRL_PERF_EN
    , .perf_releases(perf_releases), .perf_wait_cycles(perf_wait_cycles)
`endif
  );

  always #5 clk = ~clk;

  typedef struct { int id; int cyc; } exp_t;
  exp_t sb[$];
  int checks = 0, errors = 0, cyc = 0, rel_cnt = 0, rel_base;
  logic [NC-1:0] m_mask [NB];
  int            m_size [NB];
  bit            m_act  [NB];

  task automatic chk(input string tag, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Every release pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (!reset && rsp_valid) begin
      rel_cnt++;
      if (sb.size() == 0) chk("rsp_unexpected", longint'(rsp_id), -1);
      else begin
        e = sb.pop_front();
        chk("rsp_id", longint'(rsp_id), e.id);
        chk("rsp_cyc", cyc, e.cyc);
      end
    end
  end

  task automatic model_clear();
    for (int i = 0; i < NB; i++) begin m_mask[i] = '0; m_size[i] = 0; m_act[i] = 0; end
  endtask

  // Drive one arrival for one cycle and predict its release.
  task automatic arrive(input int id, input int sz, input int core);
    logic [NC-1:0] nm;
    int eff;
    req_valid = 1'b1; req_id = IW'(id); req_size_m1 = CW'(sz); req_core_id = CW'(core);
    eff = m_act[id] ? m_size[id] : sz;
    if (!m_act[id]) begin m_act[id] = 1; m_size[id] = sz; end
    nm = m_mask[id] | (NC'(1) << core);
    if ($countones(nm) == eff + 1) begin
      m_mask[id] = '0; m_act[id] = 0;
      sb.push_back('{id, cyc + 1});
    end else m_mask[id] = nm;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle(2);
    reset = 1'b0;
    model_clear();
    sb.delete();
  endtask

  initial begin
    req_valid = 0; req_id = 0; req_size_m1 = 0; req_core_id = 0; reset = 1'b0;
    model_clear();
    do_reset();
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err_dup", err_dup, 0);
    chk("rst_err_size", err_size, 0);
    chk("rst_ready", req_ready, 1);

    // Four cores at slot 1, spread arrivals; release only after the last.
    rel_base = rel_cnt;
    arrive(1, 3, 0); chk("t1_busy_first", busy, 1);
    idle(1);
    arrive(1, 3, 1);
    idle(2);         chk("t1_busy_mid", busy, 1);
    arrive(1, 3, 2);
    arrive(1, 3, 3); chk("t1_busy_done", busy, 0);
    idle(2);         chk("t1_releases", rel_cnt - rel_base, 1);

    // Single-core barrier releases on the next cycle.
    rel_base = rel_cnt;
    arrive(0, 0, 2); chk("t2_busy", busy, 0);
    idle(2);         chk("t2_releases", rel_cnt - rel_base, 1);

    // Interleaved slots 0 (two cores) and 3 (three cores).
    rel_base = rel_cnt;
    arrive(0, 1, 0); arrive(3, 2, 1); arrive(0, 1, 3);
    arrive(3, 2, 0); arrive(3, 2, 2);
    idle(2);         chk("t3_releases", rel_cnt - rel_base, 2);
    chk("t3_busy", busy, 0);

    // Duplicate arrival flags err_dup and does not advance the count.
    rel_base = rel_cnt;
    arrive(2, 1, 1); arrive(2, 1, 1);
    idle(2);
    chk("t4_err_dup", err_dup, 1);
    chk("t4_no_release", rel_cnt - rel_base, 0);
    chk("t4_busy", busy, 1);
    arrive(2, 1, 0);
    idle(2);         chk("t4_releases", rel_cnt - rel_base, 1);

    // Size mismatch: latched size of 2 cores wins.
    rel_base = rel_cnt;
    arrive(1, 1, 0); arrive(1, 2, 1);
    idle(2);
    chk("t5_err_size", err_size, 1);
    chk("t5_releases", rel_cnt - rel_base, 1);

    // Arrival right after completion opens a new epoch.
    rel_base = rel_cnt;
    arrive(2, 1, 3); arrive(2, 1, 2); arrive(2, 1, 1);
    chk("t6_busy_epoch", busy, 1);
    arrive(2, 1, 0);
    idle(2);         chk("t6_releases", rel_cnt - rel_base, 2);

    // Reset mid-barrier drops arrivals; replay releases exactly once.
    arrive(3, 3, 0); arrive(3, 3, 1);
    do_reset();
    chk("t7_busy_rst", busy, 0);
    chk("t7_err_dup_rst", err_dup, 0);
    chk("t7_err_size_rst", err_size, 0);
    rel_base = rel_cnt;
    arrive(3, 3, 0); arrive(3, 3, 1); arrive(3, 3, 2); arrive(3, 3, 3);
    idle(2);
    chk("t7_releases", rel_cnt - rel_base, 1);
    chk("t7_err_dup", err_dup, 0);
    chk("t7_err_size", err_size, 0);
`ifdef GBAR_CTRL_PERF_EN
    chk("t7_perf_releases", perf_releases, 1);
    chk("t7_perf_wait", perf_wait_cycles, 6);
`endif

    chk("sb_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
